// File: rtl/cpu_types_pkg.sv
// Shared MIPS encodings, the ID/EX control bundle and the instruction decoder.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000, J    = 6'b000010, JAL   = 6'b000011, BEQ  = 6'b000100,
    BNE   = 6'b000101, ADDI = 6'b001000, ADDIU = 6'b001001, SLTI = 6'b001010,
    SLTIU = 6'b001011, ANDI = 6'b001100, ORI   = 6'b001101, XORI = 6'b001110,
    LUI   = 6'b001111, LW   = 6'b100011, SW    = 6'b101011, LL   = 6'b110000,
    SC    = 6'b111000, HALT = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    SLL = 6'b000000, SRL = 6'b000010, JR  = 6'b001000, ADD  = 6'b100000,
    ADDU = 6'b100001, SUB = 6'b100010, SUBU = 6'b100011, AND = 6'b100100,
    OR  = 6'b100101, XOR = 6'b100110, NOR = 6'b100111, SLT  = 6'b101010,
    SLTU = 6'b101011
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'b0000, ALU_SRL = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0011,
    ALU_AND = 4'b0100, ALU_OR  = 4'b0101, ALU_XOR = 4'b0110, ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1010, ALU_SLTU = 4'b1011
  } aluop_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctl_state_t;

  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;
  localparam logic [1:0] JMP_J   = 2'd1;
  localparam logic [1:0] JMP_JAL = 2'd2;
  localparam logic [1:0] JMP_JR  = 2'd3;

  typedef struct packed {
    opcode_t    opcode;
    funct_t     funct;
    aluop_t     aluop;
    logic [4:0] shamt;
    logic       regdst, alusrc, extop, back_pad, memtoreg;
    logic       regwrite, dren, dwen;
    logic [1:0] branch, jump;
    logic       r_type, i_type, datomic, valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  // Undefined opcode/funct collapses to a bubble so nothing downstream fires.
  function automatic ctrl_t decode_instr(input logic [31:0] instr);
    ctrl_t c;
    c        = BUBBLE_CTRL;
    c.opcode = opcode_t'(instr[31:26]);
    c.funct  = funct_t'(instr[5:0]);
    c.shamt  = instr[10:6];
    c.valid  = 1'b1;
    case (c.opcode)
      RTYPE: begin
        c.r_type = 1'b1; c.regdst = 1'b1; c.regwrite = 1'b1;
        case (c.funct)
          SLL:       c.aluop = ALU_SLL;
          SRL:       c.aluop = ALU_SRL;
          ADD, ADDU: c.aluop = ALU_ADD;
          SUB, SUBU: c.aluop = ALU_SUB;
          AND:       c.aluop = ALU_AND;
          OR:        c.aluop = ALU_OR;
          XOR:       c.aluop = ALU_XOR;
          NOR:       c.aluop = ALU_NOR;
          SLT:       c.aluop = ALU_SLT;
          SLTU:      c.aluop = ALU_SLTU;
          JR: begin c.regdst = 1'b0; c.regwrite = 1'b0; c.jump = JMP_JR; end
          default:   c.valid = 1'b0;
        endcase
      end
      ADDI, ADDIU, SLTI, SLTIU: begin
        c.i_type = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; c.regwrite = 1'b1;
        c.aluop  = (c.opcode == SLTI) ? ALU_SLT : (c.opcode == SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      ANDI, ORI, XORI: begin
        c.i_type = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        c.aluop  = (c.opcode == ANDI) ? ALU_AND : (c.opcode == ORI) ? ALU_OR : ALU_XOR;
      end
      LUI: begin
        c.i_type = 1'b1; c.alusrc = 1'b1; c.back_pad = 1'b1; c.regwrite = 1'b1;
        c.aluop  = ALU_OR;
      end
      LW, LL: begin
        c.i_type = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; c.regwrite = 1'b1;
        c.dren   = 1'b1; c.memtoreg = 1'b1; c.aluop = ALU_ADD;
        c.datomic = (c.opcode == LL);
      end
      SW, SC: begin
        c.i_type = 1'b1; c.alusrc = 1'b1; c.extop = 1'b1; c.dwen = 1'b1;
        c.aluop  = ALU_ADD;
        // SC writes its success flag back to rt.
        c.regwrite = (c.opcode == SC);
        c.datomic  = (c.opcode == SC);
      end
      BEQ, BNE: begin
        c.i_type = 1'b1; c.extop = 1'b1; c.aluop = ALU_SUB;
        c.branch = (c.opcode == BEQ) ? BR_EQ : BR_NE;
      end
      J:       c.jump = JMP_J;
      JAL: begin c.jump = JMP_JAL; c.regwrite = 1'b1; end
      HALT:    ; // real instruction, but every enable stays low
      default: c.valid = 1'b0;
    endcase
    if (!c.valid) c = BUBBLE_CTRL;
    return c;
  endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC reservation: one linked address, cleared by SC or a matching snoop.
module llsc_link_reg #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll,
  input  logic              sc,
  input  logic [WORD_W-1:0] addr,
  input  logic              snoop,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              sc_success
);

  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;
  logic              snoop_hit;

  // A same-cycle snoop to the reservation kills the SC.
  always_comb begin
    snoop_hit  = snoop && (snoop_addr == link_addr_q);
    sc_success = sc && link_valid_q && (link_addr_q == addr) && !snoop_hit;
  end

  // SC consumes the link; an LL in the same cycle re-arms it afterwards.
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (sc || snoop_hit) link_valid_d = 1'b0;
    if (ll) begin
      link_addr_d  = addr;
      link_valid_d = !(snoop && (snoop_addr == addr));
    end
  end

  // Reservation register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  ll_sc_exclusive: assert property (@(posedge CLK) disable iff (!nRST) !(ll && sc));

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX control latch with stall/flush, drain-then-halt FSM and LL/SC link.
module pipelined_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned HALT_DRAIN = 3,
  parameter int unsigned LINK_EN    = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instr_i,
  input  logic              instr_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [5:0]        opcode_o,
  output logic [5:0]        r_opcode_o,
  output logic [3:0]        aluop_o,
  output logic [WORD_W-1:0] shamt_o,
  output logic              regdst_o,
  output logic              alusrc_o,
  output logic              extop_o,
  output logic              back_pad_o,
  output logic              memtoreg_o,
  output logic              regwrite_o,
  output logic              dren_o,
  output logic              dwen_o,
  output logic [1:0]        branch_o,
  output logic [1:0]        jump_o,
  output logic              r_type_o,
  output logic              i_type_o,
  output logic              datomic_o,
  output logic              ctrl_valid_o,
  output logic              halt_o,
  input  logic              mem_ll_i,
  input  logic              mem_sc_i,
  input  logic [WORD_W-1:0] mem_addr_i,
  input  logic              snoop_inv_i,
  input  logic [WORD_W-1:0] snoop_addr_i,
  output logic              sc_success_o
);

  localparam int unsigned     DrainCycles = (HALT_DRAIN == 0) ? 1 : HALT_DRAIN;
  localparam int unsigned     CntW        = $clog2(DrainCycles + 1);
  localparam logic [CntW-1:0] DrainLast   = CntW'(DrainCycles - 1);

  ctrl_t           dec, ctrl_q, ctrl_d;
  ctl_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            halted, load_halt;

  assign dec       = decode_instr(instr_i[31:0]);
  assign halted    = (state_q == HALTED);
  assign load_halt = !flush_i && !stall_i && instr_valid_i && dec.valid && (dec.opcode == HALT);

  // ID/EX next value: halted > flush > stall > load/bubble.
  always_comb begin
    ctrl_d = ctrl_q;
    if (halted || flush_i)  ctrl_d = BUBBLE_CTRL;
    else if (!stall_i)      ctrl_d = instr_valid_i ? dec : BUBBLE_CTRL;
  end

  // Halt sequencing; a flush during drain means the HALT was speculative.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (load_halt) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        if (flush_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (!stall_i) begin
          if (cnt_q == DrainLast) state_d = HALTED;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      HALTED:  ;
      default: state_d = RUN;
    endcase
  end

  // Control latch and FSM state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_q  <= BUBBLE_CTRL;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign opcode_o     = ctrl_q.opcode;
  assign r_opcode_o   = ctrl_q.funct;
  assign aluop_o      = ctrl_q.aluop;
  assign shamt_o      = {{(WORD_W-5){1'b0}}, ctrl_q.shamt};
  assign regdst_o     = ctrl_q.regdst;
  assign alusrc_o     = ctrl_q.alusrc;
  assign extop_o      = ctrl_q.extop;
  assign back_pad_o   = ctrl_q.back_pad;
  assign memtoreg_o   = ctrl_q.memtoreg;
  assign regwrite_o   = ctrl_q.regwrite;
  assign dren_o       = ctrl_q.dren;
  assign dwen_o       = ctrl_q.dwen;
  assign branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;
  assign r_type_o     = ctrl_q.r_type;
  assign i_type_o     = ctrl_q.i_type;
  assign datomic_o    = (LINK_EN != 0) ? ctrl_q.datomic : 1'b0;
  assign ctrl_valid_o = ctrl_q.valid;
  assign halt_o       = halted;

  // The reservation is frozen while halted.
  if (LINK_EN != 0) begin : g_link
    llsc_link_reg #(
      .WORD_W(WORD_W)
    ) u_link (
      .CLK        (CLK),
      .nRST       (nRST),
      .ll         (mem_ll_i && !halted),
      .sc         (mem_sc_i && !halted),
      .addr       (mem_addr_i),
      .snoop      (snoop_inv_i && !halted),
      .snoop_addr (snoop_addr_i),
      .sc_success (sc_success_o)
    );
  end else begin : g_no_link
    assign sc_success_o = 1'b0;
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: stimulus queues expectations, monitor checks each cycle.
module tb_pipelined_control_unit;

  localparam int K_NONE = -1;
  localparam int K_BUB  = 0;
  localparam int K_ADDU = 1;
  localparam int K_LW   = 2;
  localparam int K_HALT = 3;
  localparam int K_LL   = 4;
  localparam int K_SC   = 5;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;
  localparam logic [31:0] I_LL   = 32'hC022_0000;
  localparam logic [31:0] I_SC   = 32'hE022_0000;

  typedef struct {
    string name;
    int    kind;
    logic  halt;
    logic  chk_sc;
    logic  sc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic [31:0] instr = '0;
  logic        ivalid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        mll = 1'b0, msc = 1'b0, snp = 1'b0;
  logic [31:0] maddr = '0, saddr = '0;

  logic [5:0]  opcode_o, r_opcode_o;
  logic [3:0]  aluop_o;
  logic [31:0] shamt_o;
  logic        regdst_o, alusrc_o, extop_o, back_pad_o, memtoreg_o;
  logic        regwrite_o, dren_o, dwen_o, r_type_o, i_type_o, datomic_o;
  logic [1:0]  branch_o, jump_o;
  logic        ctrl_valid_o, halt_o, sc_success_o;
  logic        any_ctrl;

  assign any_ctrl = |{opcode_o, r_opcode_o, aluop_o, shamt_o, regdst_o, alusrc_o, extop_o,
                      back_pad_o, memtoreg_o, regwrite_o, dren_o, dwen_o, branch_o, jump_o,
                      r_type_o, i_type_o, datomic_o, ctrl_valid_o};

  pipelined_control_unit #(
    .WORD_W     (32),
    .HALT_DRAIN (3),
    .LINK_EN    (1)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .instr_i      (instr),
    .instr_valid_i(ivalid),
    .stall_i      (stall),
    .flush_i      (flush),
    .opcode_o     (opcode_o),
    .r_opcode_o   (r_opcode_o),
    .aluop_o      (aluop_o),
    .shamt_o      (shamt_o),
    .regdst_o     (regdst_o),
    .alusrc_o     (alusrc_o),
    .extop_o      (extop_o),
    .back_pad_o   (back_pad_o),
    .memtoreg_o   (memtoreg_o),
    .regwrite_o   (regwrite_o),
    .dren_o       (dren_o),
    .dwen_o       (dwen_o),
    .branch_o     (branch_o),
    .jump_o       (jump_o),
    .r_type_o     (r_type_o),
    .i_type_o     (i_type_o),
    .datomic_o    (datomic_o),
    .ctrl_valid_o (ctrl_valid_o),
    .halt_o       (halt_o),
    .mem_ll_i     (mll),
    .mem_sc_i     (msc),
    .mem_addr_i   (maddr),
    .snoop_inv_i  (snp),
    .snoop_addr_i (saddr),
    .sc_success_o (sc_success_o)
  );

  always #5 CLK = ~CLK;

  // {valid, regwrite, regdst, dren, dwen, memtoreg, r_type, datomic, aluop}
  function automatic logic [11:0] exp_vec(input int kind);
    case (kind)
      K_ADDU:  return 12'b1_1_1_0_0_0_1_0_0010;
      K_LW:    return 12'b1_1_0_1_0_1_0_0_0010;
      K_HALT:  return 12'b1_0_0_0_0_0_0_0_0000;
      K_LL:    return 12'b1_1_0_1_0_1_0_1_0010;
      K_SC:    return 12'b1_1_0_0_1_0_0_1_0010;
      default: return 12'b0;
    endcase
  endfunction

  function automatic logic [11:0] got_vec();
    return {ctrl_valid_o, regwrite_o, regdst_o, dren_o, dwen_o, memtoreg_o, r_type_o,
            datomic_o, aluop_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input string n, input int k, input logic h, input logic cs, input logic s);
    exp_t e;
    e.name = n; e.kind = k; e.halt = h; e.chk_sc = cs; e.sc = s;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    @(negedge CLK);
    instr = ins; ivalid = v; stall = st; flush = fl;
    mll = 1'b0; msc = 1'b0; maddr = '0; snp = 1'b0; saddr = '0;
  endtask

  task automatic link(input string n, input logic l, input logic s, input logic [31:0] a,
                      input logic sn, input logic [31:0] sa, input logic want);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);
    mll = l; msc = s; maddr = a; snp = sn; saddr = sa;
    push(n, K_BUB, 1'b0, 1'b1, want);
  endtask

  task automatic do_reset(input string n);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk({n, ".halt"}, 32'(halt_o), 32'd0);
    chk({n, ".all"}, 32'(any_ctrl), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Monitor: SC result is checked mid-cycle, control outputs just after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_sc) chk({e.name, ".sc"}, 32'(sc_success_o), 32'(e.sc));
        @(posedge CLK);
        #1;
        if (e.kind != K_NONE) chk({e.name, ".ctrl"}, 32'(got_vec()), 32'(exp_vec(e.kind)));
        chk({e.name, ".halt"}, 32'(halt_o), 32'(e.halt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 nRST = 1'b0;
    #2;
    chk("reset.all", 32'(any_ctrl), 32'd0);
    chk("reset.aluop", 32'(aluop_o), 32'd0);
    chk("reset.halt", 32'(halt_o), 32'd0);
    chk("reset.sc", 32'(sc_success_o), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Basic decode and bubble.
    cyc(I_ADDU, 1'b1, 1'b0, 1'b0); push("addu", K_ADDU, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  push("idle", K_BUB, 1'b0, 1'b0, 1'b0);

    // Stall holds LW, then flush beats stall.
    cyc(I_LW, 1'b1, 1'b0, 1'b0);   push("lw", K_LW, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(I_ADDU, 1'b1, 1'b1, 1'b0); push("lw_hold", K_LW, 1'b0, 1'b0, 1'b0);
    end
    cyc(I_ADDU, 1'b1, 1'b1, 1'b1); push("flush_stall", K_BUB, 1'b0, 1'b0, 1'b0);

    // HALT with one stalled cycle inside the drain: halt on the 4th edge after load.
    cyc(I_HALT, 1'b1, 1'b0, 1'b0); push("halt_load", K_HALT, 1'b0, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b0, 1'b0); push("drain1", K_ADDU, 1'b0, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b1, 1'b0); push("drain_stall", K_ADDU, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  push("drain2", K_BUB, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  push("halted", K_BUB, 1'b1, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b0, 1'b0); push("halted_addu", K_BUB, 1'b1, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b0, 1'b1); push("halted_flush", K_BUB, 1'b1, 1'b0, 1'b0);
    cyc(I_LW, 1'b1, 1'b1, 1'b0);   push("halted_lw", K_BUB, 1'b1, 1'b0, 1'b0);
    do_reset("rst_halted");

    // Speculative HALT flushed during drain.
    cyc(I_HALT, 1'b1, 1'b0, 1'b0); push("spec_halt", K_HALT, 1'b0, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b0, 1'b1); push("spec_flush", K_BUB, 1'b0, 1'b0, 1'b0);
    cyc(I_ADDU, 1'b1, 1'b0, 1'b0); push("spec_addu", K_ADDU, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h0, 1'b0, 1'b0, 1'b0); push("spec_idle", K_BUB, 1'b0, 1'b0, 1'b0);
    end

    // LL/SC reservation.
    link("ll_100",      1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0);
    link("sc_100",      1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1);
    link("sc_again",    1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0);
    link("ll_100b",     1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0);
    link("sc_snoop_eq", 1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
    link("ll_100c",     1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0);
    link("sc_snoop_ne", 1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b1);
    link("ll_snoop",    1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
    link("sc_after_ls", 1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0);
    link("ll_300",      1'b1, 1'b0, 32'h300, 1'b0, 32'h0,   1'b0);
    link("sc_wrong",    1'b0, 1'b1, 32'h304, 1'b0, 32'h0,   1'b0);

    // Atomic decode.
    cyc(I_LL, 1'b1, 1'b0, 1'b0);   push("ll_dec", K_LL, 1'b0, 1'b0, 1'b0);
    cyc(I_SC, 1'b1, 1'b0, 1'b0);   push("sc_dec", K_SC, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0);  push("tail", K_BUB, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the pipelined/multicore MIPS datapath.
- Decodes the instruction word into the cpu_types_pkg control set and registers it into the ID/EX control latch, with stall and flush.
- Adds a drain-then-halt state machine and an LL/SC link reservation with snoop invalidation.
- Sits between the IF/ID latch and the EX stage; one instance per core.

Parameters:
- WORD_W, 32: instruction and address width.
- HALT_DRAIN, 3: unstalled cycles after the HALT issues before halt_o asserts (lets older instructions retire).
- LINK_EN, 1: 1 enables LL/SC reservation logic; 0 forces sc_success_o=0 and datomic_o=0.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- instr_i  in  WORD_W  instruction from IF/ID.
- instr_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  hold ID/EX contents.
- flush_i  in  1  squash ID/EX (load a bubble).
- opcode_o  out  6  registered opcode_t.
- r_opcode_o  out  6  registered funct_t.
- aluop_o  out  4  registered aluop_t.
- shamt_o  out  WORD_W  zero-extended instr[10:6].
- regdst_o, alusrc_o, extop_o, back_pad_o, memtoreg_o  out  1 each  registered datapath selects.
- regwrite_o, dren_o, dwen_o  out  1 each  registered enables.
- branch_o, jump_o  out  2 each  registered branch/jump type.
- r_type_o, i_type_o, datomic_o  out  1 each  registered class flags.
- ctrl_valid_o  out  1  ID/EX holds a real instruction.
- halt_o  out  1  sticky core halt.
- mem_ll_i  in  1  LL commits in MEM this cycle.
- mem_sc_i  in  1  SC commits in MEM this cycle.
- mem_addr_i  in  WORD_W  LL/SC address.
- snoop_inv_i  in  1  coherence invalidate or remote write this cycle.
- snoop_addr_i  in  WORD_W  snooped address.
- sc_success_o  out  1  combinational SC result for the current cycle.

Behaviour:
- Reset (nRST low, async): every registered output is 0, aluop_o=ALU_SLL (encoding 0), ctrl_valid_o=0, halt_o=0, link cleared, FSM in RUN, drain counter 0.
- Decode is combinational from instr_i: opcode [31:26], funct [5:0], shamt [10:6] zero-extended. Encodings are the existing MIPS subset. LL/SC set datomic=1. SC sets regwrite=1 and dwen=1.
- Undefined opcode/funct decodes to a bubble.
- ID/EX latch update, in priority order:
  - flush_i: load bubble (all enables 0, ctrl_valid 0, aluop ALU_SLL, branch/jump 0). flush wins over stall.
  - else stall_i: hold.
  - else instr_valid_i: load the decode.
  - else: load a bubble.
- Latency: one cycle from instr_i to the control outputs.
- FSM RUN:
  - HALT (opcode 6'h3F) loaded into ID/EX goes to DRAIN, counter=0.
  - The ID/EX load of a HALT carries all enables 0.
- FSM DRAIN:
  - Counter increments on each non-stalled cycle.
  - When counter reaches HALT_DRAIN-1 on a non-stalled cycle, go to HALTED.
  - flush_i in DRAIN aborts (HALT was speculative): back to RUN, counter 0.
- FSM HALTED: halt_o=1 (registered, asserted on entry), sticky until reset. The latch is forced to bubble every cycle; instr_valid_i, stall_i and flush_i are ignored.
- HALT_DRAIN=0 is treated as 1.
- Link reservation (LINK_EN=1): link_valid plus link_addr (WORD_W, full-address compare).
  - mem_ll_i: set link_valid, link_addr=mem_addr_i.
  - mem_sc_i: sc_success_o = link_valid & (link_addr==mem_addr_i) & ~(snoop_inv_i & snoop_addr_i==link_addr). link_valid clears next cycle regardless of result.
  - snoop_inv_i with snoop_addr_i==link_addr clears link_valid.
  - Snoop to another address: no effect.
  - Simultaneous LL and snoop to the same address: link_valid ends 0 (snoop wins).
  - Simultaneous mem_ll_i and mem_sc_i: illegal. Assertion fires; SC evaluated first, then the LL sets the link.
- sc_success_o is 0 whenever mem_sc_i=0. The link is held while halted.
- Reset mid-drain or mid-link returns to the reset state immediately.

Decomposition:
- Add to cpu_types_pkg: HALT opcode constant, ctrl_t packed struct of all ID/EX control fields, ctl_state_t enum {RUN, DRAIN, HALTED}, BUBBLE_CTRL constant.
- Sub-module llsc_link_reg holds the reservation and compare (CLK, nRST, ll, sc, addr, snoop) for reuse in the cache controller.
- The decoder is a combinational function in the package.

Test Plan:
- Reset then ADDU $3,$1,$2 (0x00221821) valid, no stall: next cycle regwrite_o=1, regdst_o=1, aluop_o=ALU_ADD, r_type_o=1, ctrl_valid_o=1.
- LW held with stall_i=1 for 3 cycles, then flush_i and stall_i both 1: outputs hold LW for 3 cycles, then bubble (dren_o=0, ctrl_valid_o=0).
- HALT 0xFC000000 with HALT_DRAIN=3 and one stall inside the drain: halt_o rises exactly 4 cycles after the HALT loads and stays 1 through further stimulus.
- HALT loaded, flush_i one cycle later: FSM returns to RUN, halt_o stays 0, the following ADDU decodes normally.
- LL at 0x100, then SC at 0x100: sc_success_o=1. A second SC at 0x100 gives 0.
- LL at 0x100, snoop_inv at 0x100 in the same cycle as the SC at 0x100: sc_success_o=0. Snoop at 0x104 instead gives 1.
